// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin burst arbiter sharing one FIFO write port; define FIFO_ARB_STATS_EN to add stall_cycles/beats_total counters
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 10,
  parameter int BURST_LEN  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  input  logic                          fifo_full,
  input  logic [ADDR_WIDTH:0]           fifo_level,
  output logic                          grant_active,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          burst_done
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [31:0]                   stall_cycles,
  output logic [31:0]                   beats_total
`endif
);
  localparam int CW = $clog2(BURST_LEN + 1);
  localparam int LW = ADDR_WIDTH + 2;
  typedef enum logic {IDLE, BURST} state_t;
  state_t state_q, state_d;
  logic [ID_WIDTH-1:0] last_q, last_d, gid_q, gid_d, pick;
  logic [CW-1:0] cnt_q, cnt_d;
  logic done_q, done_d, busy, beat, room, fin;
  logic [LW-1:0] free;
  assign busy = state_q == BURST;
  assign free = LW'(DEPTH) - LW'(fifo_level);
  assign room = free >= LW'(BURST_LEN);
  assign beat = busy && req_valid[gid_q] && !fifo_full;
  assign fin = busy && ((beat && cnt_q == CW'(BURST_LEN - 1)) || (!req_valid[gid_q] && !fifo_full));
  assign req_ready = (busy && !fifo_full) ? NUM_REQ'(1) << gid_q : '0;
  assign fifo_wr_en = beat;
  assign fifo_wr_data = busy ? req_data[gid_q*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign grant_active = busy;
  assign grant_id = gid_q;
  assign burst_done = done_q;
  // first valid requester after last_grant; iterating farthest-first lets the nearest win
  always_comb begin
    pick = '0;
    for (int i = NUM_REQ; i >= 1; i--)
      if (req_valid[ID_WIDTH'((int'(last_q) + i) % NUM_REQ)]) pick = ID_WIDTH'((int'(last_q) + i) % NUM_REQ);
  end
  // grant only with room for a full burst; end on last beat or idle requester
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    gid_d = gid_q;
    cnt_d = cnt_q;
    done_d = 1'b0;
    if (!busy && |req_valid && room) begin
      state_d = BURST;
      gid_d = pick;
      cnt_d = '0;
    end
    if (beat) cnt_d = cnt_q + CW'(1);
    if (fin) begin
      state_d = IDLE;
      last_d = gid_q;
      done_d = 1'b1;
    end
  end
  // state registers; reset parks last_grant so requester 0 wins first
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q <= ID_WIDTH'(NUM_REQ - 1);
      gid_q <= '0;
      cnt_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      gid_q <= gid_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
    end
  end
`ifdef FIFO_ARB_STATS_EN
  logic [31:0] stall_q, beats_q;
  assign stall_cycles = stall_q;
  assign beats_total = beats_q;
  // saturating count of FIFO-stalled burst cycles, wrapping count of beats
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
      beats_q <= '0;
    end else begin
      if (busy && req_valid[gid_q] && fifo_full && stall_q != '1) stall_q <= stall_q + 32'd1;
      if (beat) beats_q <= beats_q + 32'd1;
    end
  end
`endif
endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin arbiter that shares the single write port of one sync_fifo instance between NUM_REQ pixel-stream producers.
- Grants one requester at a time for a burst of up to BURST_LEN beats.
- Starts a new burst only when the FIFO has room for a whole burst, so bursts complete without stalling.
- Sits between the serializers and the shared buffer. Drives the FIFO's wr_en/wr_data and consumes its full/level outputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_WIDTH, 2, width of grant_id; must satisfy 2**ID_WIDTH >= NUM_REQ
- DATA_WIDTH, 16, beat width; matches the FIFO DATA_WIDTH
- DEPTH, 1024, FIFO depth in entries
- ADDR_WIDTH, 10, FIFO address width; fifo_level is ADDR_WIDTH+1 bits
- BURST_LEN, 16, maximum beats per grant (1..DEPTH)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; synchronous, active-low
- req_valid  in  NUM_REQ  per-requester data valid
- req_data  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  per-requester accept; combinational
- fifo_wr_en  out  1  FIFO write strobe; combinational
- fifo_wr_data  out  DATA_WIDTH  FIFO write data; combinational mux
- fifo_full  in  1  FIFO full flag
- fifo_level  in  ADDR_WIDTH+1  FIFO occupancy
- grant_active  out  1  high while in BURST
- grant_id  out  ID_WIDTH  index of the granted requester
- burst_done  out  1  one-cycle pulse when a burst ends

Behaviour:
- Reset (rst_n low at a clk edge):
  - state = IDLE, last_grant = NUM_REQ-1, beat_cnt = 0.
  - grant_active = 0, grant_id = 0, burst_done = 0.
  - req_ready = 0 and fifo_wr_en = 0. fifo_wr_data is don't-care but driven to 0 while no grant is held.
  - Reset mid-burst aborts the burst immediately. No burst_done pulse is emitted.
- States: IDLE, BURST.
- IDLE:
  - req_ready = 0 and fifo_wr_en = 0.
  - room = (DEPTH - fifo_level) >= BURST_LEN, computed at ADDR_WIDTH+2 bits with no wrap.
  - If any req_valid is high and room is true: pick the first valid index searching last_grant+1, last_grant+2, ... modulo NUM_REQ. Register it into grant_id, clear beat_cnt, and go to BURST.
  - Arbitration latency: 1 cycle from valid to grant_active.
  - If room is false, stay in IDLE.
- BURST, with g = grant_id:
  - req_ready[g] = !fifo_full. All other req_ready bits are 0.
  - A beat occurs when req_valid[g] && req_ready[g]. On a beat, fifo_wr_en = 1 and fifo_wr_data = req_data[g], in the same cycle with zero latency.
  - fifo_wr_en is never asserted while fifo_full is high.
  - Each beat increments beat_cnt.
- Burst end. The burst ends at the clock edge when either:
  - a beat occurs with beat_cnt == BURST_LEN-1, or
  - req_valid[g] is low during a cycle when fifo_full is low (requester idle).
- At burst end:
  - last_grant <= g and the state returns to IDLE.
  - burst_done pulses for exactly the next cycle, aligned with the first IDLE cycle.
  - At least one IDLE cycle separates consecutive bursts, including back-to-back grants to the same requester.
- A cycle with req_valid[g] low while fifo_full is high does not end the burst; the requester is stalled by the FIFO, not idle.
- Fairness: after requester g is served, g has the lowest priority. With all requesters continuously valid, grants rotate 0,1,2,3,0,...
- A requester deasserting valid while not granted has no effect.
- grant_id holds its last value in IDLE.

Optional Feature:
- Macro FIFO_ARB_STATS_EN.
- Defined:
  - Adds output stall_cycles (32 bits): counts cycles in BURST with req_valid[g] high and fifo_full high. Saturates at 0xFFFFFFFF.
  - Adds output beats_total (32 bits): counts all beats; wraps modulo 2**32.
  - Both outputs clear on reset.
- Not defined: neither port nor its counters exist. Functionality is otherwise identical.

Test Plan:
- Reset then single requester: req_valid = 4'b0100, fifo_level = 0, 20 beats offered.
  - grant_active rises 1 cycle after valid, with grant_id = 2.
  - 16 beats are written, then burst_done pulses.
  - After 1 IDLE cycle requester 2 is re-granted and the remaining 4 beats are written.
- Round robin: all 4 requesters valid continuously, BURST_LEN = 4.
  - grant_id sequence is 0,1,2,3,0.
  - Exactly 4 fifo_wr_en pulses per grant.
  - fifo_wr_data matches each requester's data.
- Early end: requester 1 valid for 3 beats, then drops valid.
  - Burst ends after 3 beats and burst_done pulses.
  - last_grant = 1, so the next grant goes to requester 2 when it is valid.
- Full stall: fifo_full forced high for 5 cycles mid-burst with req_valid held high.
  - req_ready and fifo_wr_en stay 0 for those 5 cycles; the burst does not end.
  - It resumes and completes 16 beats in total.
  - With FIFO_ARB_STATS_EN defined, stall_cycles = 5.
- Room gate: fifo_level = 1009 (free = 15 < 16) with requester 0 valid.
  - No grant is issued.
  - When fifo_level drops to 1008, the grant is issued the next cycle.
- Reset mid-burst: rst_n low for 1 cycle after 5 beats.
  - Next cycle: grant_active = 0, req_ready = 0, no burst_done.
  - Arbitration restarts from requester 0.
